shared_mem: RTL and testbench
=============================

# shared_mem

Parametrised unified memory subsystem for the next-generation processor top level. It replaces the separate combinational instruction and data memories with one shared word-addressed array and two request channels, instruction fetch and data load/store. The block runs a round-robin arbiter and a configurable wait-state counter, and signals responses with a valid/ready request handshake. It sits between the core's fetch and memory stages and lets multicycle and pipelined cores model realistic memory latency.

## Interface
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 32: byte-address width of both channels.
- DEPTH, 256: number of words in the array; power of two.
- WAIT, 1: extra wait cycles per access, 0..15.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  instruction-fetch request.
- i_req_ready  out  1  instruction request accepted this cycle.
- i_addr  in  ADDR_W  fetch byte address.
- i_rsp_valid  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  DATA_W  fetched word.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte-lane write enables; bit k selects bits 8k+7:8k.
- d_rsp_valid  out  1  one-cycle pulse, issued for both loads and stores.
- d_rdata  out  DATA_W  load data; for a store, the word contents after the write.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: accept a request.
  - WAIT: count down the wait cycles.
  - RESP: drive the response.
- Only one transaction is outstanding at a time.
- Grant in IDLE is combinational:
  - Only one valid: that channel gets ready=1.
  - Both valid: the channel not granted last wins.
  - last_grant resets to "data", so the instruction channel wins the first tie.
  - In every other state, both ready signals are 0.
- Acceptance:
  - A request is accepted when valid&ready is high at the clock edge.
  - The block latches the channel, we, word index, wdata and be, and updates last_grant.
  - Next state is WAIT if WAIT>0, otherwise RESP.
- WAIT loads a 4-bit counter with WAIT-1 and decrements each cycle. When the counter reaches 0, the state moves to RESP.
- RESP raises rsp_valid for exactly one cycle on the granted channel only; the other channel's rsp_valid stays 0. The state then returns to IDLE.
- There is no response backpressure; the requester must take the response in the RESP cycle.
- Addressing:
  - Word index = addr[log2(DEPTH)+1 : 2].
  - Byte offset bits [1:0] are ignored; there is no misalignment fault.
  - Bits above the index are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Stores:
  - Only lanes with d_be=1 change; other lanes are preserved.
  - d_be=0 is a legal no-op store that still gets a response.
  - The array write commits on the rising edge that ends the RESP cycle.
  - d_rdata in RESP shows the merged (post-write) word.
- Loads: rdata is the array word at the latched index, read during RESP.
- The array is not reset and not initialised; its contents are undefined until written.
- Both rdata outputs hold their last driven value outside RESP.

## Timing
- Request accepted at edge t: rsp_valid is high in cycle t+1+WAIT.
  - WAIT=0: response in the cycle after acceptance.
- The next request can be accepted in the cycle after RESP. Back-to-back throughput is one access per WAIT+2 cycles.
- Reset values while reset=0:
  - state IDLE, last_grant data, counter 0, busy 0.
  - i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid: 0.
  - i_rdata, d_rdata: 0.
- Ready signals are held 0 while reset is asserted, even if a request is valid.
- Reset mid-transaction (in WAIT or RESP before the closing edge):
  - The transaction is aborted with no response.
  - A pending store is dropped and the array is unchanged.
- Deassertion of reset takes effect at the next clk edge. The first acceptance is possible in the first cycle with reset=1.
- A request arriving while busy=1 is ignored; the requester holds valid until it sees ready.

## Test plan
- WAIT=1: store 0xDEADBEEF to 0x40 with d_be=0xF, then fetch 0x40 on the instruction channel. Required: d_rsp_valid at t+2 with d_rdata 0xDEADBEEF; i_rsp_valid 2 cycles after its accept with i_rdata 0xDEADBEEF.
- Tie arbitration: hold i_req_valid and d_req_valid high from reset. Required grants I, D, I, D, each accept 3 cycles apart (WAIT=1).
- Byte lanes: word 0x10 = 0x11223344, then store 0xAABBCCDD with d_be=0b0101. Required: d_rdata = 0x11BB33DD on the store response and on a following load.
- Wrap (DEPTH=256): store 0x5 to address 0x400. Required: a load from 0x0 returns 0x5; a load from 0x402 also returns 0x5 (offset ignored).
- Reset mid-store (WAIT=3): assert reset in WAIT, release, then load the same address. Required: no d_rsp_valid pulse, and the load returns the pre-store value.
- WAIT=0: single load. Required: d_rsp_valid in the cycle immediately after acceptance; busy high for exactly 1 cycle.

Source files
------------

// File: rtl/shared_mem.sv
// shared_mem: one word-addressed array shared by an instruction-fetch channel
// and a data load/store channel. A round-robin arbiter grants one request at a
// time in IDLE, an optional wait-state count follows, and the response is a
// one-cycle pulse on the granted channel. Stores merge byte lanes and commit
// on the edge that closes the response cycle.
module shared_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WAIT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                busy
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned NB      = DATA_W / 8;
  localparam logic [3:0]  WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic {CH_I, CH_D} chan_e;

  state_e            state_q, state_d;
  chan_e             last_grant_q;
  chan_e             ch_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] d_hold_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_i;
  logic              acc_d;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rsp_word;

  // Byte offset and bits above the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[ADDR_W-1:IDX_W+2], i_addr[1:0],
                              d_addr[ADDR_W-1:IDX_W+2], d_addr[1:0]};

  assign acc_i = i_req_valid & i_req_ready;
  assign acc_d = d_req_valid & d_req_ready;
  assign busy  = (state_q != ST_IDLE);

  // Round-robin grant, only offered in IDLE and never while reset is asserted.
  always_comb begin
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    if (reset && state_q == ST_IDLE) begin
      if (i_req_valid && d_req_valid) begin
        if (last_grant_q == CH_D) i_req_ready = 1'b1;
        else                      d_req_ready = 1'b1;
      end else begin
        i_req_ready = i_req_valid;
        d_req_ready = d_req_valid;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_i || acc_d) state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Array read and byte-lane merge of the latched store data.
  always_comb begin
    rd_word = mem_q[idx_q];
    merged  = rd_word;
    for (int unsigned k = 0; k < NB; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
    rsp_word = we_q ? merged : rd_word;
  end

  // Response outputs: live during RESP, otherwise the last driven word.
  always_comb begin
    i_rsp_valid = (state_q == ST_RESP) && (ch_q == CH_I);
    d_rsp_valid = (state_q == ST_RESP) && (ch_q == CH_D);
    i_rdata     = i_rsp_valid ? rsp_word : i_hold_q;
    d_rdata     = d_rsp_valid ? rsp_word : d_hold_q;
  end

  // Request capture, arbitration history, wait counter and rdata hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= CH_D;
      ch_q         <= CH_I;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      i_hold_q     <= '0;
      d_hold_q     <= '0;
    end else begin
      if (acc_i || acc_d) begin
        ch_q         <= acc_d ? CH_D : CH_I;
        last_grant_q <= acc_d ? CH_D : CH_I;
        we_q         <= acc_d & d_we;
        idx_q        <= acc_d ? d_addr[IDX_W+1:2] : i_addr[IDX_W+1:2];
        wdata_q      <= d_wdata;
        be_q         <= d_be;
        cnt_q        <= WAIT_LD;
      end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (i_rsp_valid) i_hold_q <= rsp_word;
      if (d_rsp_valid) d_hold_q <= rsp_word;
    end
  end

  // Store commit on the edge closing RESP; a reset forces IDLE so no commit.
  always_ff @(posedge clk) begin
    if (state_q == ST_RESP && ch_q == CH_D && we_q) mem_q[idx_q] <= merged;
  end

endmodule

// File: tb/tb_shared_mem.sv
// Bench for shared_mem: three instances with WAIT = 1, 3 and 0, directed
// scenarios plus randomized traffic checked against an array/latency model.
module tb_shared_mem;

  logic        clk;
  logic        rst_n        [3];
  logic        i_req_valid_a[3];
  logic        i_req_ready_a[3];
  logic [31:0] i_addr_a     [3];
  logic        i_rsp_valid_a[3];
  logic [31:0] i_rdata_a    [3];
  logic        d_req_valid_a[3];
  logic        d_req_ready_a[3];
  logic        d_we_a       [3];
  logic [31:0] d_addr_a     [3];
  logic [31:0] d_wdata_a    [3];
  logic [3:0]  d_be_a       [3];
  logic        d_rsp_valid_a[3];
  logic [31:0] d_rdata_a    [3];
  logic        busy_a       [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mdl [3][256];
  bit          kn  [3][256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    shared_mem #(
      .DATA_W(32),
      .ADDR_W(32),
      .DEPTH (256),
      .WAIT  (g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .i_req_valid(i_req_valid_a[g]),
      .i_req_ready(i_req_ready_a[g]),
      .i_addr     (i_addr_a[g]),
      .i_rsp_valid(i_rsp_valid_a[g]),
      .i_rdata    (i_rdata_a[g]),
      .d_req_valid(d_req_valid_a[g]),
      .d_req_ready(d_req_ready_a[g]),
      .d_we       (d_we_a[g]),
      .d_addr     (d_addr_a[g]),
      .d_wdata    (d_wdata_a[g]),
      .d_be       (d_be_a[g]),
      .d_rsp_valid(d_rsp_valid_a[g]),
      .d_rdata    (d_rdata_a[g]),
      .busy       (busy_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_req(input int k);
    i_req_valid_a[k] = 1'b0;
    d_req_valid_a[k] = 1'b0;
  endtask

  // One transaction on instance k; checks handshake, latency, pulse, data, hold.
  task automatic xact(input int k, input bit ch_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, output logic [31:0] rd);
    int          w;
    int          idx;
    bit          rdy;
    bit          exp_ok;
    logic [31:0] exp;
    w   = wait_of(k);
    idx = int'(addr[9:2]);
    rd  = 'x;
    if (ch_d && we) begin
      exp    = lane_merge(mdl[k][idx], wdata, be);
      exp_ok = kn[k][idx] || (be == 4'hF);
    end else begin
      exp    = mdl[k][idx];
      exp_ok = kn[k][idx];
    end
    @(negedge clk);
    if (ch_d) begin
      d_req_valid_a[k] = 1'b1;
      d_we_a[k]        = we;
      d_addr_a[k]      = addr;
      d_wdata_a[k]     = wdata;
      d_be_a[k]        = be;
    end else begin
      i_req_valid_a[k] = 1'b1;
      i_addr_a[k]      = addr;
    end
    rdy = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      rdy = ch_d ? d_req_ready_a[k] : i_req_ready_a[k];
      if (rdy) break;
      @(negedge clk);
    end
    check("accept", 32'(rdy), 32'd1);
    if (!rdy) begin
      clear_req(k);
      return;
    end
    check("pre_busy", 32'(busy_a[k]), 32'd0);
    @(posedge clk);
    #1;
    clear_req(k);
    for (int n = 1; n <= w + 1; n++) begin
      @(negedge clk);
      check("busy", 32'(busy_a[k]), 32'd1);
      check("rsp_valid", 32'(ch_d ? d_rsp_valid_a[k] : i_rsp_valid_a[k]), 32'(n == w + 1));
      if (n == w + 1) begin
        check("rsp_other", 32'(ch_d ? i_rsp_valid_a[k] : d_rsp_valid_a[k]), 32'd0);
        rd = ch_d ? d_rdata_a[k] : i_rdata_a[k];
        if (exp_ok) check("rdata", rd, exp);
      end
    end
    @(negedge clk);
    check("idle_busy", 32'(busy_a[k]), 32'd0);
    check("idle_rsp", 32'(ch_d ? d_rsp_valid_a[k] : i_rsp_valid_a[k]), 32'd0);
    if (exp_ok) check("rdata_hold", ch_d ? d_rdata_a[k] : i_rdata_a[k], exp);
    if (ch_d && we) begin
      mdl[k][idx] = exp;
      kn[k][idx]  = exp_ok;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          grants;
    int          tie_at [4];
    bit          rdy;
    tie_at = '{0, 3, 6, 9};

    for (int k = 0; k < 3; k++) begin
      rst_n[k]         = 1'b0;
      i_req_valid_a[k] = 1'b0;
      i_addr_a[k]      = '0;
      d_req_valid_a[k] = 1'b0;
      d_we_a[k]        = 1'b0;
      d_addr_a[k]      = '0;
      d_wdata_a[k]     = '0;
      d_be_a[k]        = '0;
    end
    // Both channels request on instance 0 while still in reset.
    i_req_valid_a[0] = 1'b1;
    d_req_valid_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_i_ready", 32'(i_req_ready_a[k]), 32'd0);
      check("rst_d_ready", 32'(d_req_ready_a[k]), 32'd0);
      check("rst_busy", 32'(busy_a[k]), 32'd0);
      check("rst_i_rsp", 32'(i_rsp_valid_a[k]), 32'd0);
      check("rst_d_rsp", 32'(d_rsp_valid_a[k]), 32'd0);
      check("rst_i_rdata", i_rdata_a[k], 32'd0);
      check("rst_d_rdata", d_rdata_a[k], 32'd0);
    end

    // Tie arbitration: I, D, I, D, one grant every WAIT+2 = 3 cycles.
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    cyc    = 0;
    grants = 0;
    while (grants < 4 && cyc < 40) begin
      #1;
      check("tie_onehot", 32'(i_req_ready_a[0] & d_req_ready_a[0]), 32'd0);
      if (i_req_ready_a[0] || d_req_ready_a[0]) begin
        check("tie_cycle", 32'(cyc), 32'(tie_at[grants]));
        check("tie_chan", 32'(d_req_ready_a[0]), 32'(grants % 2));
        grants++;
        if (grants == 4) begin
          @(posedge clk);
          #1;
          clear_req(0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("tie_grants", 32'(grants), 32'd4);
    clear_req(0);
    repeat (3) @(negedge clk);

    // Full-word store then instruction fetch of the same word.
    xact(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd);
    check("st_deadbeef", rd, 32'hDEADBEEF);
    xact(0, 1'b0, 1'b0, 32'h40, '0, '0, rd);
    check("if_deadbeef", rd, 32'hDEADBEEF);

    // Byte-lane merge.
    xact(0, 1'b1, 1'b1, 32'h10, 32'h11223344, 4'hF, rd);
    xact(0, 1'b1, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, rd);
    check("lanes_store", rd, 32'h11BB33DD);
    xact(0, 1'b1, 1'b0, 32'h10, '0, '0, rd);
    check("lanes_load", rd, 32'h11BB33DD);

    // Address wrap and ignored byte offset.
    xact(0, 1'b1, 1'b1, 32'h400, 32'h5, 4'hF, rd);
    xact(0, 1'b1, 1'b0, 32'h0, '0, '0, rd);
    check("wrap_0", rd, 32'h5);
    xact(0, 1'b1, 1'b0, 32'h402, '0, '0, rd);
    check("wrap_402", rd, 32'h5);

    // Reset during WAIT drops the store and gives no response (WAIT=3).
    xact(1, 1'b1, 1'b1, 32'h80, 32'h12345678, 4'hF, rd);
    @(negedge clk);
    d_req_valid_a[1] = 1'b1;
    d_we_a[1]        = 1'b1;
    d_addr_a[1]      = 32'h80;
    d_wdata_a[1]     = 32'hCAFEF00D;
    d_be_a[1]        = 4'hF;
    rdy = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      rdy = d_req_ready_a[1];
      if (rdy) break;
      @(negedge clk);
    end
    check("mid_accept", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    clear_req(1);
    @(negedge clk);
    check("mid_busy", 32'(busy_a[1]), 32'd1);
    rst_n[1] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      #1;
      check("mid_no_rsp", 32'(d_rsp_valid_a[1]), 32'd0);
      check("mid_idle", 32'(busy_a[1]), 32'd0);
      @(negedge clk);
    end
    rst_n[1] = 1'b1;
    xact(1, 1'b1, 1'b0, 32'h80, '0, '0, rd);
    check("mid_preserved", rd, 32'h12345678);

    // WAIT=0: response the cycle after acceptance, busy for one cycle.
    xact(2, 1'b1, 1'b1, 32'h24, 32'h0BADCAFE, 4'hF, rd);
    xact(2, 1'b1, 1'b0, 32'h24, '0, '0, rd);
    check("w0_load", rd, 32'h0BADCAFE);
    xact(2, 1'b1, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, rd);
    check("w0_be0_store", rd, 32'h0BADCAFE);
    xact(2, 1'b0, 1'b0, 32'h24, '0, '0, rd);
    check("w0_be0_fetch", rd, 32'h0BADCAFE);

    // Randomized traffic over a small pre-initialised window.
    for (int k = 0; k < 3; k += 2) begin
      for (int i = 0; i < 16; i++) begin
        xact(k, 1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
      end
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        bit          chd;
        a   = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
        chd = 1'($urandom_range(0, 1));
        xact(k, chd, chd & 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
